alu_op_scheduler: RTL and testbench

Shares one iterative multiplier and one iterative divider among `NUM_REQ` requesters. Each request carries an opcode and two operands. The block arbitrates round-robin, runs one operation at a time, and returns the result tagged with the requester ID. It sits between the UART-facing command FSMs and the multiply/divide units, so several command front-ends can reuse one arithmetic datapath.

---
 rtl/alu_sched_pkg.sv | 25 ++
 rtl/alu_op_scheduler_rr_arbiter.sv | 37 +++
 rtl/alu_op_scheduler.sv | 161 ++++++++++++++++
 tb/tb_alu_op_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// +-----------------------------------------------------------------------------+
// | alu_sched_pkg: opcode and FSM state types for alu_op_scheduler.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package alu_sched_pkg;

  typedef enum logic [1:0] {
    OP_INV = 2'b00,
    OP_ADD = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// +-----------------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick, searching from last+1 upward.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = ID_W'((int'(last) + off) % NUM_REQ);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        id           = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_scheduler.sv
// +-----------------------------------------------------------------------------+
// | alu_op_scheduler: round-robin sharing of one multiplier and one divider     |
// | among NUM_REQ requesters, one operation in flight.  Revision: 1.0           |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [2*NUM_REQ-1:0]     req_op_i,
  input  logic [WIDTH*NUM_REQ-1:0] req_a_i,
  input  logic [WIDTH*NUM_REQ-1:0] req_b_i,
  output logic                     mul_v_o,
  input  logic                     mul_ready_and_i,
  output logic [WIDTH-1:0]         mul_opa_o,
  output logic [WIDTH-1:0]         mul_opb_o,
  input  logic                     mul_v_i,
  input  logic [WIDTH-1:0]         mul_result_i,
  output logic                     mul_yumi_o,
  output logic                     div_v_o,
  input  logic                     div_ready_and_i,
  output logic [WIDTH-1:0]         div_dividend_o,
  output logic [WIDTH-1:0]         div_divisor_o,
  input  logic                     div_v_i,
  input  logic [WIDTH-1:0]         div_quotient_i,
  output logic                     div_yumi_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     rsp_err_o
);

  state_e            r_state;
  op_e               r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_last;
  logic [WIDTH-1:0]  r_data;
  logic              r_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_id;
  logic               w_any;
  logic               w_accept;
  logic               w_issue_hs;
  op_e                w_sel_op;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid_i),
    .last  (r_last),
    .grant (w_grant),
    .id    (w_id),
    .any   (w_any)
  );

  assign w_sel_op = op_e'(req_op_i[2*w_id +: 2]);
  assign w_sel_a  = req_a_i[WIDTH*w_id +: WIDTH];
  assign w_sel_b  = req_b_i[WIDTH*w_id +: WIDTH];

  // The arbiter only grants valid requesters, so a grant in IDLE is an accept.
  assign w_accept    = (r_state == IDLE) && w_any;
  assign req_ready_o = (r_state == IDLE) ? w_grant : '0;

  assign mul_v_o        = (r_state == ISSUE) && (r_op == OP_MUL);
  assign div_v_o        = (r_state == ISSUE) && (r_op == OP_DIV);
  assign mul_opa_o      = r_a;
  assign mul_opb_o      = r_b;
  assign div_dividend_o = r_a;
  assign div_divisor_o  = r_b;
  assign w_issue_hs     = (mul_v_o && mul_ready_and_i) || (div_v_o && div_ready_and_i);

  assign mul_yumi_o = (r_state == WAIT) && (r_op == OP_MUL) && mul_v_i;
  assign div_yumi_o = (r_state == WAIT) && (r_op == OP_DIV) && div_v_i;

  assign rsp_valid_o = (r_state == RESP);
  assign rsp_id_o    = r_id;
  assign rsp_data_o  = r_data;
  assign rsp_err_o   = r_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_op    <= OP_INV;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id <= w_id;
            r_op <= w_sel_op;
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            case (w_sel_op)
              OP_ADD: begin
                r_data  <= w_sel_a + w_sel_b;
                r_err   <= 1'b0;
                r_state <= RESP;
              end
              OP_MUL: r_state <= ISSUE;
              OP_DIV: begin
                // Divide by zero is answered locally, never dispatched.
                if (w_sel_b == '0) begin
                  r_data  <= '1;
                  r_err   <= 1'b1;
                  r_state <= RESP;
                end else begin
                  r_state <= ISSUE;
                end
              end
              default: begin
                r_data  <= '0;
                r_err   <= 1'b1;
                r_state <= RESP;
              end
            endcase
          end
        end
        ISSUE: begin
          if (w_issue_hs) r_state <= WAIT;
        end
        WAIT: begin
          if (mul_yumi_o || div_yumi_o) begin
            r_data  <= (r_op == OP_MUL) ? mul_result_i : div_quotient_i;
            r_err   <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_last  <= r_id;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
// +-----------------------------------------------------------------------------+
// | tb_alu_op_scheduler: scoreboard bench with behavioural mul/div units.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_op_scheduler;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [3:0]  req_op_i;
  logic [63:0] req_a_i;
  logic [63:0] req_b_i;
  logic        mul_v_o, mul_ready_and_i, mul_v_i, mul_yumi_o;
  logic [31:0] mul_opa_o, mul_opb_o, mul_result_i;
  logic        div_v_o, div_ready_and_i, div_v_i, div_yumi_o;
  logic [31:0] div_dividend_o, div_divisor_o, div_quotient_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [0:0]  rsp_id_o;
  logic [31:0] rsp_data_o;

  logic mul_uv, div_uv, spur_mul, spur_div;
  assign mul_v_i = mul_uv | spur_mul;
  assign div_v_i = div_uv | spur_div;

  int   n_pass, n_total, n_rsp, n_div_v, unit_lat;
  exp_t sb[$];

  alu_op_scheduler #(.NUM_REQ(2), .WIDTH(32), .ID_W(1)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .mul_v_o(mul_v_o), .mul_ready_and_i(mul_ready_and_i), .mul_opa_o(mul_opa_o),
    .mul_opb_o(mul_opb_o), .mul_v_i(mul_v_i), .mul_result_i(mul_result_i),
    .mul_yumi_o(mul_yumi_o),
    .div_v_o(div_v_o), .div_ready_and_i(div_ready_and_i), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_v_i(div_v_i), .div_quotient_i(div_quotient_i),
    .div_yumi_o(div_yumi_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!reset_i && rsp_valid_o && rsp_ready_i) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_queue_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
        chk("rsp_data", rsp_data_o, e.data);
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
  end

  always @(negedge clk) if (div_v_o) n_div_v++;

  // Behavioural multiplier: result unit_lat cycles after issue, held until yumi.
  initial begin : mul_unit
    logic [31:0] ua, ub;
    bit aborted;
    mul_uv = 1'b0;
    mul_result_i = '0;
    forever begin
      @(negedge clk);
      if (!reset_i && mul_v_o && mul_ready_and_i) begin
        ua = mul_opa_o; ub = mul_opb_o; aborted = 1'b0;
        for (int k = 0; k < unit_lat; k++) begin
          @(negedge clk);
          if (reset_i) aborted = 1'b1;
        end
        if (!aborted) begin
          mul_result_i = ua * ub;
          mul_uv = 1'b1;
          for (int k = 0; k < 50 && mul_uv; k++) begin
            #1;
            if (reset_i) mul_uv = 1'b0;
            else if (mul_yumi_o) begin @(posedge clk); #1 mul_uv = 1'b0; end
            else @(negedge clk);
          end
          mul_uv = 1'b0;
        end
      end
    end
  end

  initial begin : div_unit
    logic [31:0] ua, ub;
    bit aborted;
    div_uv = 1'b0;
    div_quotient_i = '0;
    forever begin
      @(negedge clk);
      if (!reset_i && div_v_o && div_ready_and_i) begin
        ua = div_dividend_o; ub = div_divisor_o; aborted = 1'b0;
        for (int k = 0; k < unit_lat; k++) begin
          @(negedge clk);
          if (reset_i) aborted = 1'b1;
        end
        if (!aborted) begin
          div_quotient_i = (ub == 0) ? 32'hDEAD_BEEF : ua / ub;
          div_uv = 1'b1;
          for (int k = 0; k < 50 && div_uv; k++) begin
            #1;
            if (reset_i) div_uv = 1'b0;
            else if (div_yumi_o) begin @(posedge clk); #1 div_uv = 1'b0; end
            else @(negedge clk);
          end
          div_uv = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op_i[2*id +: 2] = op;
    req_a_i[32*id +: 32] = a;
    req_b_i[32*id +: 32] = b;
  endtask

  // Single requester transaction; lat = cycles from accept to rsp_valid_o.
  task automatic issue(input int id, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    bit acc;
    int base;
    set_req(id, op, a, b);
    req_valid_i[id] = 1'b1;
    acc = 1'b0;
    lat = -1;
    for (int k = 0; k < 30 && !acc; k++) begin
      #1;
      if (req_ready_o[id]) begin
        acc = 1'b1;
        chk("grant_onehot", 32'(req_ready_o), 32'(1 << id));
      end
      @(posedge clk); #1;
    end
    req_valid_i[id] = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    base = n_rsp;
    for (int k = 1; k <= 60; k++) begin
      if (lat < 0 && rsp_valid_o) lat = k;
      if (n_rsp != base) break;
      step();
    end
    if (n_rsp == base) chk("rsp_timeout", 32'(n_rsp - base), 32'd1);
  endtask

  task automatic wait_rsps(input int target, input string name);
    int base;
    base = n_rsp;
    for (int k = 0; k < 300; k++) begin
      step();
      if (n_rsp - base >= target) break;
    end
    req_valid_i = 2'b00;
    chk(name, 32'(n_rsp - base), 32'(target));
  endtask

  initial begin : stim
    int lat, dv0;
    n_pass = 0; n_total = 0; n_rsp = 0; n_div_v = 0; unit_lat = 2;
    reset_i = 1'b1; req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    mul_ready_and_i = 1'b1; div_ready_and_i = 1'b1; rsp_ready_i = 1'b1;
    spur_mul = 1'b0; spur_div = 1'b0;
    step(); step();
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_mul_v", 32'(mul_v_o), 32'd0);
    chk("reset_div_v", 32'(div_v_o), 32'd0);
    chk("reset_req_ready", 32'(req_ready_o), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id_o), 32'd0);
    chk("reset_rsp_data", rsp_data_o, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    reset_i = 1'b0;
    step();

    // add 5+7
    sb.push_back('{id: 1'b0, data: 32'd12, err: 1'b0});
    issue(0, 2'b01, 32'd5, 32'd7, lat);
    chk("add_latency", 32'(lat), 32'd1);

    // divide by zero, then a real divide
    dv0 = n_div_v;
    sb.push_back('{id: 1'b1, data: 32'hFFFF_FFFF, err: 1'b1});
    issue(1, 2'b11, 32'd100, 32'd0, lat);
    chk("divzero_latency", 32'(lat), 32'd1);
    chk("divzero_no_dispatch", 32'(n_div_v), 32'(dv0));
    sb.push_back('{id: 1'b1, data: 32'd14, err: 1'b0});
    issue(1, 2'b11, 32'd100, 32'd7, lat);
    chk("div_dispatched", 32'(n_div_v != dv0), 32'd1);

    // fairness: both requesters multiply continuously
    for (int i = 0; i < 4; i++) sb.push_back('{id: 1'(i % 2), data: 32'd12, err: 1'b0});
    set_req(0, 2'b10, 32'd3, 32'd4);
    set_req(1, 2'b10, 32'd3, 32'd4);
    req_valid_i = 2'b11;
    wait_rsps(4, "fairness_count");
    step();

    // back-pressure on the response channel
    rsp_ready_i = 1'b0;
    sb.push_back('{id: 1'b0, data: 32'd30, err: 1'b0});
    set_req(0, 2'b01, 32'd10, 32'd20);
    req_valid_i = 2'b01;
    step();
    set_req(1, 2'b10, 32'd2, 32'd2);
    req_valid_i = 2'b11;
    spur_mul = 1'b1; spur_div = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id_o), 32'd0);
      chk("bp_rsp_data", rsp_data_o, 32'd30);
      chk("bp_rsp_err", 32'(rsp_err_o), 32'd0);
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
      chk("bp_unit_v", 32'({mul_v_o, div_v_o}), 32'd0);
      chk("bp_stray_yumi", 32'({mul_yumi_o, div_yumi_o}), 32'd0);
      step();
    end
    req_valid_i = 2'b00;
    spur_mul = 1'b0; spur_div = 1'b0;
    rsp_ready_i = 1'b1;
    step(); step();

    // multiplier issue stall
    mul_ready_and_i = 1'b0;
    sb.push_back('{id: 1'b1, data: 32'd42, err: 1'b0});
    set_req(1, 2'b10, 32'd6, 32'd7);
    req_valid_i = 2'b10;
    step();
    req_valid_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_mul_v", 32'(mul_v_o), 32'd1);
      chk("stall_opa", mul_opa_o, 32'd6);
      chk("stall_opb", mul_opb_o, 32'd7);
      step();
    end
    mul_ready_and_i = 1'b1;
    step();
    chk("stall_release_mul_v", 32'(mul_v_o), 32'd0);
    wait_rsps(1, "stall_rsp_count");
    step();

    // reset while waiting on the multiplier
    unit_lat = 20;
    set_req(0, 2'b10, 32'd2, 32'd3);
    req_valid_i = 2'b01;
    step();
    req_valid_i = 2'b00;
    step(); step();
    reset_i = 1'b1;
    step();
    chk("rstmid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rstmid_unit_v", 32'({mul_v_o, div_v_o}), 32'd0);
    chk("rstmid_yumi", 32'({mul_yumi_o, div_yumi_o}), 32'd0);
    chk("rstmid_rsp_data", rsp_data_o, 32'd0);
    chk("rstmid_rsp_id_err", 32'({rsp_id_o, rsp_err_o}), 32'd0);
    reset_i = 1'b0;
    unit_lat = 2;
    step();
    sb.push_back('{id: 1'b0, data: 32'd2, err: 1'b0});
    sb.push_back('{id: 1'b1, data: 32'd4, err: 1'b0});
    set_req(0, 2'b01, 32'd1, 32'd1);
    set_req(1, 2'b01, 32'd2, 32'd2);
    req_valid_i = 2'b11;
    #1;
    chk("post_reset_grant", 32'(req_ready_o), 32'd1);
    wait_rsps(2, "post_reset_rsp_count");
    step(); step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
